ysyx_25060166_ctrl_fsm: RTL
===========================

# ysyx_25060166_ctrl_fsm

Multi-cycle sequencer for the RV32E NPC core: owns the PC and instruction register and steps each instruction through fetch, execute, optional memory access and write-back. It drives the instruction-fetch handshake and presents the latched instruction to the combinational decoder. From the decoder it takes the memory and write-enable flags, and it gates register-file writes and the LSU request accordingly. It sits between the fetch bus, decoder, EXU/LSU and register file, replacing free-running single-cycle commit.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 1024, maximum wait cycles for a fetch or LSU response; used only with the timeout feature.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ifu_req  out  1  fetch request, held until accepted.
- ifu_addr  out  32  fetch address, equals pc.
- ifu_rvalid  in  1  fetch data valid.
- ifu_rdata  in  32  fetched instruction.
- inst  out  32  instruction register, feeds the decoder.
- dec_mem_ren, dec_mem_wen, dec_reg_wen, dec_ebreak  in  1 each  decoder flags for inst.
- lsu_req  out  1  memory access request, held until done.
- lsu_done  in  1  LSU access complete; load data valid this cycle.
- npc  in  32  next PC from EXU (pc+4 or branch/jump target).
- pc  out  32  current PC.
- rf_wen  out  1  register-file write strobe.
- commit  out  1  one-cycle pulse per retired instruction.
- halt  out  1  sticky; core stopped.
- err  out  1  sticky; bus timeout (see Configuration).

## Operation
- States: IDLE, FETCH, EXEC, MEM, WB, HALT.
- IDLE: entered on reset. Moves to FETCH unconditionally after one cycle.
- FETCH:
  - ifu_req=1.
  - On ifu_rvalid: inst<=ifu_rdata, then go to EXEC.
  - ifu_rvalid outside FETCH is ignored.
- EXEC: one cycle; decoder and EXU are combinational on inst. Next state:
  - dec_ebreak → HALT (highest priority).
  - dec_mem_ren|dec_mem_wen → MEM.
  - otherwise → WB.
- MEM: lsu_req=1. On lsu_done, go to WB.
- WB:
  - rf_wen=dec_reg_wen.
  - commit=1.
  - pc<=npc.
  - Then go to FETCH.
- HALT: absorbing. All requests and strobes are 0, halt=1. Only rst_n exits.
- rf_wen is asserted only in WB; stores and branches never write.
- pc changes only in WB. npc is sampled as a 32-bit value; no alignment check is done here.
- Both dec_mem_ren and dec_mem_wen set: treated as a single MEM access. The LSU resolves the direction.

## Timing
- Reset values:
  - state=IDLE, pc=RESET_PC, inst=32'h0000_0013 (nop).
  - ifu_req=0, lsu_req=0, rf_wen=0, commit=0, halt=0, err=0.
- rst_n low mid-transaction: requests drop immediately (asynchronous). Any pending bus response is discarded.
- All outputs are registered or a pure decode of state; there are no combinational paths from input to output except through the decoder flags.
- Non-memory instruction, ifu_rvalid in the first FETCH cycle: FETCH, EXEC, WB = 3 cycles per instruction.
- Memory instruction, lsu_done in the first MEM cycle: 4 cycles per instruction.
- Each extra wait cycle on ifu_rvalid or lsu_done adds exactly one cycle.
- First ifu_req is asserted in the 2nd cycle after rst_n deasserts.

## Configuration
- Macro YSYX_25060166_TIMEOUT_EN.
- Defined:
  - A 16-bit wait counter clears on entry to FETCH or MEM and increments each cycle the awaited response is absent.
  - When the counter reaches TIMEOUT_CYCLES: err<=1 and the FSM goes to HALT. No commit occurs.
  - A response arriving in the same cycle the counter reaches TIMEOUT_CYCLES wins; no error is raised.
- Not defined: no counter; err is tied 0; FETCH and MEM wait indefinitely.

## Test plan
- Reset, then ifu_rvalid always 1 with addi instructions → ifu_addr 0x80000000, 0x80000004, …; commit every 3rd cycle; rf_wen coincides with commit.
- lw with lsu_done delayed 5 cycles → lsu_req high for 6 cycles; instruction takes 9 cycles; rf_wen=1 in WB.
- sw (dec_reg_wen=0) → lsu_req asserted; WB has commit=1, rf_wen=0; pc advances by npc.
- jal with npc=0x80000100 → next ifu_addr=0x80000100.
- Instruction 0x00100073 with dec_ebreak=1 → HALT; halt=1; no commit; ifu_req stays 0 until rst_n pulse.
- With macro, TIMEOUT_CYCLES=8, ifu_rvalid never asserted → err=1 and halt=1 after 8 FETCH wait cycles. Pulsing rst_n low mid-FETCH clears both; pc returns to 0x80000000.

Source files
------------

// File: rtl/ysyx_25060166_ctrl_fsm.sv
// Multi-cycle IDLE/FETCH/EXEC/MEM/WB/HALT sequencer owning PC and instruction register.
// Optional bus-timeout watchdog is enabled by defining YSYX_25060166_TIMEOUT_EN.
module ysyx_25060166_ctrl_fsm #(
    parameter logic [31:0] RESET_PC       = 32'h8000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ifu_req,
    output logic [31:0] ifu_addr,
    input  logic        ifu_rvalid,
    input  logic [31:0] ifu_rdata,
    output logic [31:0] inst,
    input  logic        dec_mem_ren,
    input  logic        dec_mem_wen,
    input  logic        dec_reg_wen,
    input  logic        dec_ebreak,
    output logic        lsu_req,
    input  logic        lsu_done,
    input  logic [31:0] npc,
    output logic [31:0] pc,
    output logic        rf_wen,
    output logic        commit,
    output logic        halt,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        err_q, err_d;

`ifdef YSYX_25060166_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    logic [15:0] wait_q, wait_d;
    logic        wait_expired;

    // Counter value after this cycle's miss equals the limit.
    assign wait_expired = (wait_q + 16'd1) == TIMEOUT_LIM;
`else
    // Limit only matters when the watchdog is built in.
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout_limit
    end
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (ifu_rvalid) begin
                    inst_d  = ifu_rdata;
                    state_d = S_EXEC;
                end
`ifdef YSYX_25060166_TIMEOUT_EN
                else if (wait_expired) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end
`endif
            end
            S_EXEC: begin
                if (dec_ebreak) begin
                    state_d = S_HALT;
                end else if (dec_mem_ren || dec_mem_wen) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (lsu_done) begin
                    state_d = S_WB;
                end
`ifdef YSYX_25060166_TIMEOUT_EN
                else if (wait_expired) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end
`endif
            end
            S_WB: begin
                pc_d    = npc;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef YSYX_25060166_TIMEOUT_EN
    // Counts only while parked in a waiting state; any transition restarts it.
    always_comb begin
        wait_d = '0;
        if ((state_q == S_FETCH || state_q == S_MEM) && state_d == state_q) begin
            wait_d = wait_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
        end
    end

    assign ifu_req  = (state_q == S_FETCH);
    assign ifu_addr = pc_q;
    assign inst     = inst_q;
    assign pc       = pc_q;
    assign lsu_req  = (state_q == S_MEM);
    assign rf_wen   = (state_q == S_WB) && dec_reg_wen;
    assign commit   = (state_q == S_WB);
    assign halt     = (state_q == S_HALT);
    assign err      = err_q;

endmodule
